// File: rtl/uart_tx_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// uart_tx_arbiter : round-robin sharing of one UART byte transmitter
// Rev 1.0
// ============================================================================
module uart_tx_arbiter #(
    parameter int NREQ       = 4,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 4096
) (
    input  logic              sys_clk,
    input  logic              sys_rst_l,
    input  logic [NREQ-1:0]   req_i,
    input  logic [8*NREQ-1:0] data_i,
    output logic [NREQ-1:0]   gnt_o,
    output logic              xmitH,
    output logic [7:0]        xmit_dataH,
    input  logic              xmit_doneH,
    output logic              busy_o,
    output logic              err_o,
    input  logic              clr_err_i
);

    localparam int PW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic [3:0]      gcnt_q, gcnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            xmit_q, xmit_d;
    logic [7:0]      data_q, data_d;
    logic            err_q, err_d;
    logic            busy_q;

    logic [PW-1:0]   win;
    logic            win_vld;
    logic [PW:0]     idx;
    logic [PW:0]     win_inc;
    logic            timeout_hit;
    logic            gap_done;

    // Scan from the pointer upward with wrap; first pending requester wins.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        idx     = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = {1'b0, ptr_q} + (PW+1)'(i);
            if (idx >= (PW+1)'(NREQ)) begin
                idx = idx - (PW+1)'(NREQ);
            end
            if (!win_vld && req_i[idx[PW-1:0]]) begin
                win_vld = 1'b1;
                win     = idx[PW-1:0];
            end
        end
        win_inc = {1'b0, win} + (PW+1)'(1);
        if (win_inc >= (PW+1)'(NREQ)) begin
            win_inc = '0;
        end
    end

    assign timeout_hit = (tcnt_q == TW'(TIMEOUT - 1));
    // GAP_CYCLES of 0 still spends one cycle in GAP.
    assign gap_done    = (({1'b0, gcnt_q} + 5'd1) >= 5'(GAP_CYCLES));

    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            tcnt_q  <= '0;
            gcnt_q  <= '0;
            gnt_q   <= '0;
            xmit_q  <= 1'b0;
            data_q  <= 8'h00;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            tcnt_q  <= tcnt_d;
            gcnt_q  <= gcnt_d;
            gnt_q   <= gnt_d;
            xmit_q  <= xmit_d;
            data_q  <= data_d;
            err_q   <= err_d;
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (win_vld) state_d = ST_WAIT;
            ST_WAIT: if (xmit_doneH || timeout_hit) state_d = ST_GAP;
            ST_GAP:  if (gap_done) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        gnt_d  = '0;
        xmit_d = 1'b0;
        data_d = data_q;
        ptr_d  = ptr_q;
        tcnt_d = '0;
        gcnt_d = '0;
        // Clear is applied first so a coincident timeout set overrides it.
        err_d  = clr_err_i ? 1'b0 : err_q;
        case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    gnt_d  = NREQ'(1) << win;
                    xmit_d = 1'b1;
                    data_d = data_i[{win, 3'b000} +: 8];
                    ptr_d  = win_inc[PW-1:0];
                end
            end
            ST_WAIT: begin
                if (!xmit_doneH) begin
                    if (timeout_hit) begin
                        err_d = 1'b1;
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
            end
            ST_GAP: begin
                if (!gap_done) begin
                    gcnt_d = gcnt_q + 4'd1;
                end
            end
            default: ;
        endcase
    end

    assign gnt_o      = gnt_q;
    assign xmitH      = xmit_q;
    assign xmit_dataH = data_q;
    assign busy_o     = busy_q;
    assign err_o      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// Bench for uart_tx_arbiter: directed scenarios followed by random transactions
// checked against a transaction-level round-robin model.
module tb_uart_tx_arbiter;

    localparam int NREQ   = 4;
    localparam int GAP    = 2;
    localparam int TO     = 16;
    localparam int GAPLEN = (GAP == 0) ? 1 : GAP;

    logic              sys_clk = 1'b0;
    logic              sys_rst_l;
    logic [NREQ-1:0]   req_i;
    logic [8*NREQ-1:0] data_i;
    logic [NREQ-1:0]   gnt_o;
    logic              xmitH;
    logic [7:0]        xmit_dataH;
    logic              xmit_doneH;
    logic              busy_o;
    logic              err_o;
    logic              clr_err_i;

    int         n_cmp = 0;
    int         n_err = 0;
    int         m_ptr = 0;
    logic       m_err = 1'b0;
    logic [7:0] prev_data = 8'h00;

    uart_tx_arbiter #(.NREQ(NREQ), .GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
        .sys_clk    (sys_clk),
        .sys_rst_l  (sys_rst_l),
        .req_i      (req_i),
        .data_i     (data_i),
        .gnt_o      (gnt_o),
        .xmitH      (xmitH),
        .xmit_dataH (xmit_dataH),
        .xmit_doneH (xmit_doneH),
        .busy_o     (busy_o),
        .err_o      (err_o),
        .clr_err_i  (clr_err_i)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then check the always-true invariants.
    task automatic tick();
        @(posedge sys_clk);
        #1;
        chk("onehot", 32'($countones(gnt_o) <= 1), 32'd1);
        chk("gnt_iff_xmit", 32'(gnt_o != '0), 32'(xmitH));
        if (!xmitH) chk("data_hold", 32'(xmit_dataH), 32'(prev_data));
        prev_data = xmit_dataH;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) tick();
    endtask

    function automatic int rr_win(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic do_reset();
        sys_rst_l = 1'b0;
        #1;
        chk("rst_gnt",  32'(gnt_o), 32'd0);
        chk("rst_xmit", 32'(xmitH), 32'd0);
        chk("rst_data", 32'(xmit_dataH), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_err",  32'(err_o), 32'd0);
        #2;
        sys_rst_l = 1'b1;
        m_ptr     = 0;
        m_err     = 1'b0;
        prev_data = 8'h00;
    endtask

    task automatic expect_grant(input string tag, input int w, input logic [7:0] b);
        tick();
        chk({tag, "_gnt"},  32'(gnt_o), 32'(1) << w);
        chk({tag, "_xmit"}, 32'(xmitH), 32'd1);
        chk({tag, "_data"}, 32'(xmit_dataH), 32'(b));
        chk({tag, "_busy"}, 32'(busy_o), 32'd1);
        m_ptr = (w + 1) % NREQ;
    endtask

    // Drive done in the current cycle and check the gap that follows.
    task automatic finish_done(input string tag);
        xmit_doneH = 1'b1;
        tick();
        xmit_doneH = 1'b0;
        chk({tag, "_err"}, 32'(err_o), 32'(m_err));
        for (int k = 0; k < GAPLEN; k++) begin
            if (k > 0) tick();
            chk({tag, "_gapbusy"}, 32'(busy_o), 32'd1);
            chk({tag, "_gapgnt"},  32'(gnt_o), 32'd0);
        end
        tick();
        chk({tag, "_idlebusy"}, 32'(busy_o), 32'd0);
        chk({tag, "_idlegnt"},  32'(gnt_o), 32'd0);
    endtask

    initial begin
        logic [31:0]     d;
        logic [NREQ-1:0] r;
        int              w;
        int              k;

        sys_rst_l  = 1'b0;
        req_i      = '0;
        data_i     = '0;
        xmit_doneH = 1'b0;
        clr_err_i  = 1'b0;
        @(posedge sys_clk);
        #1;
        do_reset();

        // Single request
        d = {8'h43, 8'hA5, 8'h21, 8'h10};
        req_i = 4'b0100; data_i = d;
        expect_grant("single", 2, 8'hA5);
        req_i = '0;
        wait_cycles(10);
        chk("single_wait_busy", 32'(busy_o), 32'd1);
        finish_done("single");

        // Round-robin fairness from a fresh pointer
        @(posedge sys_clk); #1;
        do_reset();
        d = {8'h43, 8'h32, 8'h21, 8'h10};
        req_i = 4'b1111; data_i = d;
        for (int i = 0; i < 5; i++) begin
            w = i % NREQ;
            expect_grant("rr", w, d[8*w +: 8]);
            wait_cycles(5);
            finish_done("rr");
        end

        // Pointer wrap
        req_i = 4'b1000;
        expect_grant("wrap3", 3, d[31:24]);
        req_i = 4'b1001;
        wait_cycles(3);
        finish_done("wrap3");
        expect_grant("wrap0", 0, d[7:0]);
        wait_cycles(3);
        finish_done("wrap0");
        expect_grant("wrap3b", 3, d[31:24]);
        req_i = '0;
        wait_cycles(3);
        finish_done("wrap3b");

        // Timeout, with a clear coinciding with the set
        req_i = 4'b0001;
        expect_grant("to", 0, d[7:0]);
        req_i = '0;
        wait_cycles(14);
        chk("to_err_early", 32'(err_o), 32'd0);
        tick();
        clr_err_i = 1'b1;
        tick();
        clr_err_i = 1'b0;
        chk("to_err_set", 32'(err_o), 32'd1);
        chk("to_busy_gap", 32'(busy_o), 32'd1);
        m_err = 1'b1;
        tick();
        chk("to_busy_gap2", 32'(busy_o), 32'd1);
        tick();
        chk("to_idle", 32'(busy_o), 32'd0);
        tick();
        chk("to_sticky", 32'(err_o), 32'd1);
        clr_err_i = 1'b1;
        tick();
        clr_err_i = 1'b0;
        chk("to_clr", 32'(err_o), 32'd0);
        m_err = 1'b0;

        // Done coinciding with the last timeout cycle
        req_i = 4'b0001;
        expect_grant("coinc", rr_win(4'b0001, m_ptr), d[7:0]);
        req_i = '0;
        wait_cycles(TO - 1);
        finish_done("coinc");

        // Done in IDLE is ignored
        xmit_doneH = 1'b1;
        tick();
        xmit_doneH = 1'b0;
        chk("idle_done_busy", 32'(busy_o), 32'd0);
        chk("idle_done_gnt",  32'(gnt_o), 32'd0);
        tick();
        chk("idle_done_busy2", 32'(busy_o), 32'd0);

        // Request raised in WAIT waits out the gap
        req_i = 4'b0010;
        expect_grant("wreq1", 1, d[15:8]);
        req_i = '0;
        wait_cycles(2);
        req_i = 4'b0100;
        wait_cycles(2);
        finish_done("wreq");
        expect_grant("wreq2", 2, d[23:16]);
        req_i = '0;

        // Request raised and dropped within GAP is never granted
        wait_cycles(3);
        xmit_doneH = 1'b1;
        tick();
        xmit_doneH = 1'b0;
        req_i = 4'b1000;
        tick();
        req_i = '0;
        tick();
        chk("gapdrop_idle", 32'(busy_o), 32'd0);
        tick();
        chk("gapdrop_gnt", 32'(gnt_o), 32'd0);
        chk("gapdrop_busy", 32'(busy_o), 32'd0);

        // Asynchronous reset while waiting on the transmitter
        d = {8'h77, 8'h5A, 8'h66, 8'h55};
        req_i = 4'b0100; data_i = d;
        expect_grant("ar", rr_win(4'b0100, m_ptr), 8'h5A);
        req_i = '0;
        wait_cycles(2);
        chk("ar_hold", 32'(xmit_dataH), 32'h5A);
        do_reset();
        req_i = 4'b0010;
        expect_grant("ar_post", 1, 8'h66);
        req_i = '0;
        wait_cycles(3);
        finish_done("ar_post");
        req_i = 4'b0111;
        expect_grant("ar_ptr2", 2, 8'h5A);
        req_i = '0;
        wait_cycles(3);
        finish_done("ar_ptr2");

        // Random transactions against the round-robin model
        for (int t = 0; t < 40; t++) begin
            r = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            d = $urandom;
            w = rr_win(r, m_ptr);
            req_i = r; data_i = d;
            expect_grant("rnd", w, d[8*w +: 8]);
            req_i = NREQ'($urandom);
            if ($urandom_range(0, 5) == 0) begin
                wait_cycles(TO);
                chk("rnd_to_err", 32'(err_o), 32'd1);
                chk("rnd_to_busy", 32'(busy_o), 32'd1);
                wait_cycles(GAPLEN);
                chk("rnd_to_idle", 32'(busy_o), 32'd0);
                req_i = '0;
                clr_err_i = 1'b1;
                tick();
                clr_err_i = 1'b0;
                chk("rnd_to_clr", 32'(err_o), 32'd0);
            end else begin
                k = $urandom_range(1, TO - 1);
                wait_cycles(k);
                finish_done("rnd");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
